// File: rtl/multih_best_state_sel_if.sv
// Candidate-stream and frame-result bundle for the multi-h best-state selector.
// master drives candidates and reads results; slave is the selector itself.
interface multih_best_state_sel_if #(
    parameter int size = 8
);
    logic            candValid;
    logic            candFirst;
    logic            candLast;
    logic [5:0]      candIndex;
    logic [size-1:0] candVal;
    logic            bestValid;
    logic [5:0]      bestIndex;
    logic [size-1:0] bestVal;
    logic            frameErr;

    modport master (
        output candValid, candFirst, candLast, candIndex, candVal,
        input  bestValid, bestIndex, bestVal, frameErr
    );

    modport slave (
        input  candValid, candFirst, candLast, candIndex, candVal,
        output bestValid, bestIndex, bestVal, frameErr
    );
endinterface

// File: rtl/multih_best_state_sel.sv
// Frame-level signed maximum tracker over the compare-tree winner stream.
// Optional frame-length check is built when MULTIH_FRAME_CHECK_EN is defined.
module multih_best_state_sel #(
    parameter int size     = 8,
    parameter int numCands = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multih_best_state_sel_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [5:0]      run_idx_q, run_idx_d;
    logic [size-1:0] run_val_q, run_val_d;
    logic [5:0]      best_idx_q, best_idx_d;
    logic [size-1:0] best_val_q, best_val_d;
    logic            best_valid_q, best_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            emit_s;
    logic            greater_s;
    logic [5:0]      final_idx_s;
    logic [size-1:0] final_val_s;

`ifdef MULTIH_FRAME_CHECK_EN
    logic [6:0] cnt_q, cnt_d;
`else
    localparam int unused_num_cands = numCands;
`endif

    assign greater_s = $signed(bus.candVal) > $signed(run_val_q);

    // Next-state, running max and result capture
    always_comb begin
        state_d      = state_q;
        run_idx_d    = run_idx_q;
        run_val_d    = run_val_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        best_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        emit_s       = 1'b0;
        final_idx_s  = run_idx_q;
        final_val_s  = run_val_q;
`ifdef MULTIH_FRAME_CHECK_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.candValid && bus.candFirst) begin
                    final_idx_s = bus.candIndex;
                    final_val_s = bus.candVal;
`ifdef MULTIH_FRAME_CHECK_EN
                    cnt_d = 7'd1;
`endif
                    emit_s  = bus.candLast;
                    state_d = bus.candLast ? IDLE : ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (bus.candValid) begin
                    // A candFirst here is a restart: the open frame is dropped silently
                    if (bus.candFirst || greater_s) begin
                        final_idx_s = bus.candIndex;
                        final_val_s = bus.candVal;
                    end else begin
                        final_idx_s = run_idx_q;
                        final_val_s = run_val_q;
                    end
`ifdef MULTIH_FRAME_CHECK_EN
                    cnt_d = bus.candFirst ? 7'd1 : (cnt_q + 7'd1);
`endif
                    emit_s  = bus.candLast;
                    state_d = bus.candLast ? IDLE : ACCUM;
                end else begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        run_idx_d = final_idx_s;
        run_val_d = final_val_s;

        if (emit_s) begin
            best_idx_d   = final_idx_s;
            best_val_d   = final_val_s;
            best_valid_d = 1'b1;
`ifdef MULTIH_FRAME_CHECK_EN
            frame_err_d  = (cnt_d != 7'(numCands));
`else
            frame_err_d  = 1'b0;
`endif
        end else begin
            best_valid_d = 1'b0;
            frame_err_d  = 1'b0;
        end
    end

    // State, running max and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            run_idx_q    <= 6'd0;
            run_val_q    <= '0;
            best_idx_q   <= 6'd0;
            best_val_q   <= '0;
            best_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_idx_q    <= run_idx_d;
            run_val_q    <= run_val_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            best_valid_q <= best_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef MULTIH_FRAME_CHECK_EN
    // Accepted-candidate counter for the frame-length check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 7'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.bestValid = best_valid_q;
    assign bus.bestIndex = best_idx_q;
    assign bus.bestVal   = best_val_q;
    assign bus.frameErr  = frame_err_q;
endmodule

// File: tb/tb_multih_best_state_sel.sv
// Table-driven bench for multih_best_state_sel with a strobe scoreboard.
module tb_multih_best_state_sel;
    localparam int SIZE = 8;
    localparam int NC   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multih_best_state_sel_if #(.size(SIZE)) bus ();
    multih_best_state_sel #(.size(SIZE), .numCands(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v, f, l;
        logic [5:0] idx;
        int         val;
        logic       ev;
        logic [5:0] eidx;
        int         eval;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic [5:0] idx;
        int         val;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   last_idx = 0;
    int   last_val = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, f, l, input int idx, val,
                                input logic ev = 1'b0, input int eidx = 0,
                                input int eval = 0, input logic eerr = 1'b0);
        vec_t r;
        r.v = v; r.f = f; r.l = l; r.idx = 6'(idx); r.val = val;
        r.ev = ev; r.eidx = 6'(eidx); r.eval = eval; r.eerr = eerr;
        vecs.push_back(r);
    endfunction

    task automatic step(input vec_t r);
        exp_t e;
        logic [31:0] vbits;
        vbits         = r.val;
        bus.candValid = r.v;
        bus.candFirst = r.f;
        bus.candLast  = r.l;
        bus.candIndex = r.idx;
        bus.candVal   = vbits[SIZE-1:0];
        if (r.ev) begin
            e.idx = r.eidx;
            e.val = r.eval;
`ifdef MULTIH_FRAME_CHECK_EN
            e.err = r.eerr;
`else
            e.err = 1'b0;
`endif
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("strobe", int'(bus.bestValid), 1);
            chk("best_idx", int'(bus.bestIndex), int'(e.idx));
            chk("best_val", int'($signed(bus.bestVal)), e.val);
            chk("frame_err", int'(bus.frameErr), int'(e.err));
            last_idx = int'(e.idx);
            last_val = e.val;
        end else begin
            chk("no_strobe", int'(bus.bestValid), 0);
            chk("hold_idx", int'(bus.bestIndex), last_idx);
            chk("hold_val", int'($signed(bus.bestVal)), last_val);
            chk("no_err", int'(bus.frameErr), 0);
        end
    endtask

    initial begin
        vec_t r;
        // Frame A: 16 ascending values at index 4k, max on the last one
        for (int i = 0; i < 16; i++)
            add(1'b1, i == 0, i == 15, 4 * i, i, i == 15, 60, 15, 1'b0);
        add(1'b0, 1'b0, 1'b0, 0, 0);
        // Candidates in IDLE without candFirst are ignored
        add(1'b1, 1'b0, 1'b0, 5, 100);
        add(1'b1, 1'b0, 1'b1, 6, 100);
        // Frame B: mixed signs, tie keeps the earlier index
        add(1'b1, 1'b1, 1'b0, 3, -128);
        add(1'b1, 1'b0, 1'b0, 7, -1);
        add(1'b1, 1'b0, 1'b0, 11, 5);
        add(1'b1, 1'b0, 1'b1, 15, 5, 1'b1, 11, 5, 1'b1);
        // Frame C: all negative with a gap carrying don't-care flags
        add(1'b1, 1'b1, 1'b0, 0, -3);
        add(1'b0, 1'b1, 1'b1, 9, 99);
        add(1'b1, 1'b0, 1'b0, 1, -2);
        add(1'b1, 1'b0, 1'b0, 2, -2);
        add(1'b1, 1'b0, 1'b1, 3, -100, 1'b1, 1, -2, 1'b1);
        // Frame D: single candidate, then a back-to-back 16-candidate frame
        add(1'b1, 1'b1, 1'b1, 42, -7, 1'b1, 42, -7, 1'b1);
        for (int i = 0; i < 16; i++)
            add(1'b1, i == 0, i == 15, i, (i == 9) ? 50 : -i, i == 15, 9, 50, 1'b0);
        // Restart: first five (max 90) abandoned, then 16 counted candidates
        add(1'b1, 1'b1, 1'b0, 0, 10);
        add(1'b1, 1'b0, 1'b0, 1, 90);
        add(1'b1, 1'b0, 1'b0, 2, 30);
        add(1'b1, 1'b0, 1'b0, 3, 40);
        add(1'b1, 1'b0, 1'b0, 4, 50);
        add(1'b1, 1'b1, 1'b0, 5, 10);
        for (int k = 0; k < 15; k++)
            add(1'b1, 1'b0, k == 14, 20 + k, (k == 13) ? 20 : k, k == 14, 33, 20, 1'b0);
        // Restart combined with last inside ACCUM
        add(1'b1, 1'b1, 1'b0, 1, 0);
        add(1'b1, 1'b0, 1'b0, 2, 3);
        add(1'b1, 1'b1, 1'b1, 50, -9, 1'b1, 50, -9, 1'b1);
        // Extremes of metric range and index 63
        add(1'b1, 1'b1, 1'b0, 63, -128);
        add(1'b1, 1'b0, 1'b1, 10, 127, 1'b1, 10, 127, 1'b1);
        add(1'b1, 1'b1, 1'b0, 63, 127);
        add(1'b1, 1'b0, 1'b1, 0, 127, 1'b1, 63, 127, 1'b1);

        bus.candValid = 1'b0; bus.candFirst = 1'b0; bus.candLast = 1'b0;
        bus.candIndex = 6'd0; bus.candVal = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.bestValid), 0);
        chk("rst_idx", int'(bus.bestIndex), 0);
        chk("rst_val", int'($signed(bus.bestVal)), 0);
        chk("rst_err", int'(bus.frameErr), 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset mid-frame: outputs clear at once, the frame tail is ignored
        for (int i = 0; i < 8; i++) begin
            r = '{1'b1, i == 0, 1'b0, 6'(i), i + 1, 1'b0, 6'd0, 0, 1'b0};
            step(r);
        end
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(bus.bestValid), 0);
        chk("async_rst_idx", int'(bus.bestIndex), 0);
        chk("async_rst_val", int'($signed(bus.bestVal)), 0);
        bus.candValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_idx = 0;
        last_val = 0;
        for (int i = 8; i < 16; i++) begin
            r = '{1'b1, 1'b0, i == 15, 6'(i), 100 + i, 1'b0, 6'd0, 0, 1'b0};
            step(r);
        end
        r = '{1'b0, 1'b0, 1'b0, 6'd0, 0, 1'b0, 6'd0, 0, 1'b0};
        step(r);
        r = '{1'b1, 1'b1, 1'b1, 6'd5, 3, 1'b1, 6'd5, 3, 1'b1};
        step(r);
        r = '{1'b0, 1'b0, 1'b0, 6'd0, 0, 1'b0, 6'd0, 0, 1'b0};
        step(r);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multih_best_state_sel.md
# multih_best_state_sel

Frame-level best-state selector for the multi-h trellis demodulator. It is the downstream reader of the 4-way compare tree. It consumes the stream of per-group winners (6-bit state index plus two's-complement metric) produced one per clock by the compare stages. Across one symbol frame it tracks the overall maximum metric and its state index, then presents the global best state to the traceback and metric-normalization logic with a one-cycle strobe.

## Interface
- `size`, default 8, metric width in bits (two's complement).
- `numCands`, default 16, expected candidates per frame (64 states / 4-way groups); used only by the frame check.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `candValid` input 1: candidate present this cycle.
- `candFirst` input 1: first candidate of a frame; qualified by `candValid`.
- `candLast` input 1: last candidate of a frame; qualified by `candValid`.
- `candIndex` input 6: state index of the candidate, 0-63.
- `candVal` input size: candidate metric, two's complement.
- `bestValid` output 1: one-cycle strobe when a frame result is ready.
- `bestIndex` output 6: state index of the frame maximum.
- `bestVal` output size: frame maximum metric.
- `frameErr` output 1: one-cycle strobe coincident with `bestValid` when the frame length is wrong. Constant 0 when the check is compiled out.

## Operation
- Two states:
  - IDLE: no frame open.
  - ACCUM: frame open; running max held in `runIdx` / `runVal`.
- Compare is signed two's complement. A candidate replaces the running max only if strictly greater. On ties the earlier candidate is kept.
- IDLE:
  - `candValid & candFirst` loads `runIdx`/`runVal` from the candidate and moves to ACCUM.
  - If `candLast` is also set (single-candidate frame), the result is emitted and the block stays in IDLE.
  - `candValid` without `candFirst` is ignored.
- ACCUM with `candValid`:
  - `candFirst`: abandon the open frame with no output, reload from the candidate, stay in ACCUM. This is a restart.
  - Otherwise: compare and update the running max.
  - `candLast` (without `candFirst`): the final max includes this candidate; emit the result and go to IDLE.
  - `candFirst & candLast` together: reload, emit the single-candidate result, go to IDLE.
- ACCUM without `candValid`: hold state. Gaps between candidates are legal.
- Emitting a result:
  - Register the final max into `bestIndex`/`bestVal`.
  - Pulse `bestValid` for one cycle.
  - `bestIndex`/`bestVal` hold until the next emit.
- `candIndex` is passed through untouched. No offset is added; offsets are applied upstream.

## Timing
- Reset values: state IDLE; `runIdx`, `runVal`, `bestIndex`, `bestVal` = 0; `bestValid` = 0; `frameErr` = 0; candidate counter = 0.
- Latency: `bestValid` is high on the first clock after the cycle in which `candLast` is sampled.
- Back-to-back frames: `candFirst` may arrive the cycle immediately after `candLast`. No bubble is required and throughput is one candidate per clock.
- Reset asserted mid-frame: the frame is discarded, all outputs clear immediately (asynchronous), and no strobe is produced.
- `candFirst`/`candLast`/`candIndex`/`candVal` are don't-care when `candValid` = 0.

## Configuration
- `MULTIH_FRAME_CHECK_EN` defined:
  - A 7-bit counter loads 1 on each accepted `candFirst` and increments on each other accepted candidate.
  - At emit, `frameErr` pulses with `bestValid` if count ≠ `numCands`.
  - A restart inside ACCUM reloads the counter to 1.
- Not defined: no counter is built, and `frameErr` is tied to 0. The `frameErr` port exists in both builds.

## Test plan
- Frame of 16 candidates, index 4k, values 0..15 ascending, with value 15 on the last → `bestValid` one clock after last, `bestIndex`=60, `bestVal`=15, `frameErr`=0.
- Mixed signs: values -128, -1, 5, 5 at indices 3, 7, 11, 15 (4-candidate frame) → `bestIndex`=11, `bestVal`=5 (tie keeps earlier). With the check enabled and `numCands`=16, `frameErr`=1.
- All negative: -3, -2, -2, -100 at indices 0, 1, 2, 3 → `bestIndex`=1, `bestVal`=-2.
- Single frame with `candFirst` & `candLast` in the same cycle, index 42, value -7 → next cycle `bestValid`=1, `bestIndex`=42, `bestVal`=-7. Then a back-to-back frame starting next cycle is accepted without loss.
- Restart: 5 candidates (max 90), then a new `candFirst` with value 10, then 15 more candidates (max 20 at index 33) ending in last → a single strobe with `bestIndex`=33, `bestVal`=20, `frameErr`=0.
- Reset pulse asserted after 8 candidates of a frame, then the remaining 8 candidates without `candFirst` → no `bestValid`, outputs stay 0. Candidates are ignored until the next `candFirst`.
